// File: rtl/fp_posit4_acc_if.sv
// rtl/fp_posit4_acc_if.sv - operand/result bundle for the posit accumulate stage
interface fp_posit4_acc_if #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 14,
  parameter int ACC_W  = 32
);
  logic              start;
  logic              sign_in;
  logic [EXP_W-1:0]  exp_set;
  logic [ACC_W-1:0]  fixed_point_acc;
  logic [EXP_W-1:0]  exp_in;
  logic [FRAC_W-1:0] fixed_point_in;
  logic              zero;
  logic              NaR;
  logic [EXP_W-1:0]  exp_out;
  logic [ACC_W-1:0]  fixed_point_out;

  modport master (
    output start, sign_in, exp_set, fixed_point_acc, exp_in, fixed_point_in, zero, NaR,
    input  exp_out, fixed_point_out
  );

  modport slave (
    input  start, sign_in, exp_set, fixed_point_acc, exp_in, fixed_point_in, zero, NaR,
    output exp_out, fixed_point_out
  );
endinterface

// File: rtl/fp_posit4_acc.sv
// rtl/fp_posit4_acc.sv - two-stage align and saturating add/sub into a fixed-point accumulator
module fp_posit4_acc #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 14,
  parameter int ACC_W  = 32
) (
  input  logic           clk,
  input  logic           rst,
  fp_posit4_acc_if.slave bus
);
  // Wide enough to hold the largest left shift without losing bits.
  localparam int SH_W  = FRAC_W + (1 << EXP_W);
  localparam int SUM_W = SH_W + 2;

  localparam logic [ACC_W-1:0] NAR_CODE = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] SAT_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN  = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};
  localparam logic signed [SUM_W-1:0] SAT_MAX_EXT = {{(SUM_W-ACC_W){1'b0}}, SAT_MAX};
  localparam logic signed [SUM_W-1:0] SAT_MIN_EXT = {{(SUM_W-ACC_W){1'b1}}, SAT_MIN};

  logic [SH_W-1:0]  mag_ext;
  logic [SH_W-1:0]  aligned;

  logic             s1_valid;
  logic             s1_sign;
  logic             s1_zero;
  logic             s1_nar;
  logic [EXP_W-1:0] s1_exp_set;
  logic [ACC_W-1:0] s1_acc;
  logic [SH_W-1:0]  s1_aligned;

  logic signed [SUM_W-1:0] acc_ext;
  logic signed [SUM_W-1:0] term;
  logic signed [SUM_W-1:0] sum;
  logic [ACC_W-1:0]        result;

  logic [EXP_W-1:0] exp_q;
  logic [ACC_W-1:0] out_q;

  always_comb begin
    mag_ext = SH_W'(bus.fixed_point_in);
    aligned = mag_ext;
    if (bus.exp_in < bus.exp_set)
      aligned = mag_ext >> (bus.exp_set - bus.exp_in);
    else if (bus.exp_in > bus.exp_set)
      aligned = mag_ext << (bus.exp_in - bus.exp_set);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_zero    <= 1'b0;
      s1_nar     <= 1'b0;
      s1_exp_set <= '0;
      s1_acc     <= '0;
      s1_aligned <= '0;
    end else begin
      s1_valid <= bus.start;
      if (bus.start) begin
        s1_sign    <= bus.sign_in;
        s1_zero    <= bus.zero;
        s1_nar     <= bus.NaR;
        s1_exp_set <= bus.exp_set;
        s1_acc     <= bus.fixed_point_acc;
        s1_aligned <= aligned;
      end
    end
  end

  always_comb begin
    acc_ext = {{(SUM_W-ACC_W){s1_acc[ACC_W-1]}}, s1_acc};
    term    = {2'b00, s1_aligned};
    sum     = s1_sign ? (acc_ext - term) : (acc_ext + term);
    result  = sum[ACC_W-1:0];
    // NaR input or NaR accumulator poisons the result before anything else.
    if (s1_nar || (s1_acc == NAR_CODE))
      result = NAR_CODE;
    else if (s1_zero)
      result = s1_acc;
    else if (sum > SAT_MAX_EXT)
      result = SAT_MAX;
    else if (sum < SAT_MIN_EXT)
      result = SAT_MIN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0;
      out_q <= '0;
    end else if (s1_valid) begin
      exp_q <= s1_exp_set;
      out_q <= result;
    end
  end

  assign bus.exp_out         = exp_q;
  assign bus.fixed_point_out = out_q;
endmodule

// File: tb/tb_fp_posit4_acc.sv
// tb/tb_fp_posit4_acc.sv - randomized and directed self-checking bench for fp_posit4_acc
module tb_fp_posit4_acc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_posit4_acc_if bus ();

  fp_posit4_acc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          due;
    logic [31:0] val;
    logic [4:0]  e;
  } pend_t;

  pend_t       pend[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] hold_val = 32'h0;
  logic [4:0]  hold_exp = 5'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] ref_result(input bit sg, input int es, input int ei,
                                             input logic [31:0] acc, input int fin,
                                             input bit z, input bit nar);
    longint al;
    longint s;
    if (nar || acc == 32'h8000_0000) return 32'h8000_0000;
    if (z) return acc;
    if (ei < es) al = longint'(fin) / (longint'(1) << (es - ei));
    else         al = longint'(fin) * (longint'(1) << (ei - es));
    s = longint'($signed(acc));
    s = sg ? s - al : s + al;
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483647) s = -64'sd2147483647;
    return s[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (pend.size() > 0 && pend[0].due <= cyc) begin
      hold_val = pend[0].val;
      hold_exp = pend[0].e;
      void'(pend.pop_front());
    end
    check_eq("out", bus.fixed_point_out, hold_val);
    check_eq("exp", 32'(bus.exp_out), 32'(hold_exp));
  endtask

  task automatic scramble();
    bus.sign_in         = 1'($urandom);
    bus.exp_set         = 5'($urandom);
    bus.exp_in          = 5'($urandom);
    bus.fixed_point_acc = $urandom;
    bus.fixed_point_in  = 14'($urandom);
    bus.zero            = 1'($urandom);
    bus.NaR             = 1'($urandom);
  endtask

  task automatic issue(input bit sg, input logic [4:0] es, input logic [4:0] ei,
                       input logic [31:0] acc, input logic [13:0] fin,
                       input bit z, input bit nar);
    pend_t p;
    bus.start           = 1'b1;
    bus.sign_in         = sg;
    bus.exp_set         = es;
    bus.exp_in          = ei;
    bus.fixed_point_acc = acc;
    bus.fixed_point_in  = fin;
    bus.zero            = z;
    bus.NaR             = nar;
    p.due = cyc + 2;
    p.val = ref_result(sg, int'(es), int'(ei), acc, int'(fin), z, nar);
    p.e   = es;
    pend.push_back(p);
    tick();
    bus.start = 1'b0;
    scramble();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.start = 1'b0;
      scramble();
      tick();
    end
  endtask

  initial begin
    logic [31:0] acc;
    rst       = 1'b1;
    bus.start = 1'b0;
    scramble();
    idle(2);
    check_eq("reset_out", bus.fixed_point_out, 32'h0);
    check_eq("reset_exp", 32'(bus.exp_out), 32'h0);
    rst = 1'b0;
    idle(2);

    issue(1'b0, 5'd16, 5'd15, 32'h1, 14'h21F6, 1'b0, 1'b0);
    check_eq("align_latency_hold", bus.fixed_point_out, 32'h0);
    idle(1);
    check_eq("align_add", bus.fixed_point_out, 32'h0000_10FC);
    check_eq("align_exp", 32'(bus.exp_out), 32'd16);

    issue(1'b1, 5'd10, 5'd10, 32'h100, 14'h0180, 1'b0, 1'b0);
    idle(1);
    check_eq("subtract", bus.fixed_point_out, 32'hFFFF_FF80);

    issue(1'b0, 5'd5, 5'd7, 32'h1234, 14'h3FFF, 1'b1, 1'b0);
    idle(1);
    check_eq("zero_pass", bus.fixed_point_out, 32'h0000_1234);

    issue(1'b0, 5'd5, 5'd7, 32'h1234, 14'h3FFF, 1'b1, 1'b1);
    idle(1);
    check_eq("nar_over_zero", bus.fixed_point_out, 32'h8000_0000);

    issue(1'b0, 5'd5, 5'd25, 32'h7FFF_0000, 14'h3FFF, 1'b0, 1'b0);
    idle(1);
    check_eq("sat_max", bus.fixed_point_out, 32'h7FFF_FFFF);

    issue(1'b1, 5'd5, 5'd25, 32'h8000_0010, 14'h3FFF, 1'b0, 1'b0);
    idle(1);
    check_eq("sat_min", bus.fixed_point_out, 32'h8000_0001);

    issue(1'b0, 5'd20, 5'd6, 32'h55, 14'h3FFF, 1'b0, 1'b0);
    idle(1);
    check_eq("rshift14", bus.fixed_point_out, 32'h0000_0055);

    issue(1'b0, 5'd3, 5'd3, 32'h8000_0000, 14'h0001, 1'b0, 1'b0);
    idle(1);
    check_eq("nar_acc", bus.fixed_point_out, 32'h8000_0000);

    issue(1'b0, 5'd1, 5'd1, 32'h10, 14'h1, 1'b0, 1'b0);
    issue(1'b0, 5'd2, 5'd2, 32'h20, 14'h2, 1'b0, 1'b0);
    check_eq("b2b_first", bus.fixed_point_out, 32'h11);
    issue(1'b0, 5'd3, 5'd3, 32'h30, 14'h3, 1'b0, 1'b0);
    check_eq("b2b_second", bus.fixed_point_out, 32'h22);
    idle(1);
    check_eq("b2b_third", bus.fixed_point_out, 32'h33);
    idle(1);

    issue(1'b0, 5'd9, 5'd9, 32'h1000, 14'h0FFF, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("rst_async_out", bus.fixed_point_out, 32'h0);
    check_eq("rst_async_exp", 32'(bus.exp_out), 32'h0);
    pend.delete();
    hold_val = 32'h0;
    hold_exp = 5'h0;
    idle(2);
    rst = 1'b0;
    idle(3);
    check_eq("rst_flush", bus.fixed_point_out, 32'h0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 4))
          0:       acc = 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
          1:       acc = 32'h8000_0001 + 32'($urandom_range(0, 255));
          2:       acc = 32'h8000_0000;
          default: acc = $urandom;
        endcase
        issue(1'($urandom), 5'($urandom), 5'($urandom), acc, 14'($urandom),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0));
      end else begin
        idle(1);
      end
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
